// File: rtl/dsp_result_sig.sv
// Result-bus signature collector: captures the settled DUT result per vector,
// folds it into a 32-bit MISR and streams the signature out as bytes.
module dsp_result_sig #(
    parameter int unsigned ZW     = 108,
    parameter int unsigned SETTLE = 2,
    parameter logic [31:0] POLY   = 32'h04C1_1DB7,
    parameter logic [31:0] SEED   = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   num_vec,
    input  logic          vec_valid,
    output logic          vec_ready,
    input  logic [ZW-1:0] z,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);
    localparam int unsigned SIG_W  = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PAD_W  = 128;
    localparam int unsigned SCNT_W = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VEC,
        S_SETTLE,
        S_FOLD,
        S_SEND,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [SIG_W-1:0]    sig_q, sig_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    nvec_q, nvec_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [1:0]          k_q, k_d;
    logic [ZW-1:0]       zcap_q, zcap_d;
    logic                vec_ready_q, vec_ready_d;
    logic                tx_valid_q, tx_valid_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [PAD_W-1:0]    zpad;
    logic [SIG_W-1:0]    chunk;
    logic [SIG_W-1:0]    folded;
    logic [CNT_W-1:0]    cnt_inc;
    logic [1:0]          k_inc;

    // Byte idx of the signature, most significant byte first.
    function automatic logic [BYTE_W-1:0] sig_byte(input logic [SIG_W-1:0] s,
                                                    input logic [1:0] idx);
        return s[{~idx, 3'b000} +: BYTE_W];
    endfunction

    always_comb begin
        zpad    = PAD_W'(zcap_q);
        chunk   = zpad[{k_q, 5'b00000} +: SIG_W];
        folded  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ chunk;
        cnt_inc = cnt_q + CNT_W'(1);
        k_inc   = k_q + 2'd1;

        state_d     = state_q;
        sig_d       = sig_q;
        cnt_d       = cnt_q;
        nvec_d      = nvec_q;
        scnt_d      = scnt_q;
        k_d         = k_q;
        zcap_d      = zcap_q;
        vec_ready_d = vec_ready_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sig_d  = SEED;
                    cnt_d  = '0;
                    nvec_d = num_vec;
                    busy_d = 1'b1;
                    if (num_vec == '0) begin
                        state_d    = S_SEND;
                        k_d        = 2'd0;
                        tx_valid_d = 1'b1;
                        tx_data_d  = sig_byte(SEED, 2'd0);
                    end else begin
                        state_d     = S_WAIT_VEC;
                        vec_ready_d = 1'b1;
                    end
                end
            end
            S_WAIT_VEC: begin
                if (vec_valid && vec_ready_q) begin
                    scnt_d      = SCNT_W'(SETTLE - 1);
                    vec_ready_d = 1'b0;
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (scnt_q == '0) begin
                    zcap_d  = z;
                    k_d     = 2'd0;
                    state_d = S_FOLD;
                end else begin
                    scnt_d = scnt_q - SCNT_W'(1);
                end
            end
            S_FOLD: begin
                sig_d = folded;
                k_d   = k_inc;
                if (k_q == 2'd3) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == nvec_q) begin
                        state_d    = S_SEND;
                        k_d        = 2'd0;
                        tx_valid_d = 1'b1;
                        tx_data_d  = sig_byte(folded, 2'd0);
                    end else begin
                        state_d     = S_WAIT_VEC;
                        vec_ready_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                // Advance only on a completed handshake; data holds otherwise.
                if (tx_valid_q && tx_ready) begin
                    if (k_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        k_d       = k_inc;
                        tx_data_d = sig_byte(sig_q, k_inc);
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sig_q       <= SEED;
            cnt_q       <= '0;
            nvec_q      <= '0;
            scnt_q      <= '0;
            k_q         <= '0;
            zcap_q      <= '0;
            vec_ready_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            cnt_q       <= cnt_d;
            nvec_q      <= nvec_d;
            scnt_q      <= scnt_d;
            k_q         <= k_d;
            zcap_q      <= zcap_d;
            vec_ready_q <= vec_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign vec_ready = vec_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
